// File: rtl/ex_bus_dmem.sv
// ex_bus_dmem: dual-read / dual-write data memory on the external data bus.
// Registered reads with write-first forwarding, wr_1-over-wr_0 collision
// priority per word, sticky out-of-range trap, and a sequential clear engine.
module ex_bus_dmem #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 64,
    parameter int MEM_AW         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    output logic              o_busy,
    input  logic [ADDR_W-1:0] i_rd_0_addr,
    input  logic              i_rd_0_en,
    input  logic              i_rd_0_x2_en,
    output logic [DATA_W-1:0] o_rd_0_data,
    output logic [DATA_W-1:0] o_rd_0_data_x2,
    output logic              o_rd_0_valid,
    input  logic [ADDR_W-1:0] i_rd_1_addr,
    input  logic              i_rd_1_en,
    input  logic              i_rd_1_x2_en,
    output logic [DATA_W-1:0] o_rd_1_data,
    output logic [DATA_W-1:0] o_rd_1_data_x2,
    output logic              o_rd_1_valid,
    input  logic [ADDR_W-1:0] i_wr_0_addr,
    input  logic              i_wr_0_en,
    input  logic              i_wr_0_x2_en,
    input  logic [DATA_W-1:0] i_wr_0_data,
    input  logic [DATA_W-1:0] i_wr_0_data_x2,
    input  logic [ADDR_W-1:0] i_wr_1_addr,
    input  logic              i_wr_1_en,
    input  logic              i_wr_1_x2_en,
    input  logic [DATA_W-1:0] i_wr_1_data,
    input  logic [DATA_W-1:0] i_wr_1_data_x2,
    output logic              o_oor_err
);

    localparam int DEPTH = 2 ** MEM_AW;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state_q;
    logic [MEM_AW-1:0]   clr_cnt_q;
    logic                rst_seen_q;
    logic                oor_q;
    logic [DATA_W-1:0]   rd0_data_q, rd0_data_x2_q, rd1_data_q, rd1_data_x2_q;
    logic                rd0_valid_q, rd1_valid_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Word lanes: index 0/1 = port 0 addr/addr+1, 2/3 = port 1 addr/addr+1.
    // Higher index wins on the same word, which gives wr_1 priority.
    logic [3:0][ADDR_W-1:0] wa, ra;
    logic [3:0][DATA_W-1:0] wd, rdv;
    logic [3:0]             wv, we, rv;
    logic                   busy, oor_hit;

    assign busy = (state_q == S_CLEAR);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:MEM_AW] == '0;
    endfunction

    // Expand both ports into per-word lanes; addr+1 wraps within ADDR_W bits.
    always_comb begin
        wa[0] = i_wr_0_addr;
        wa[1] = i_wr_0_addr + ADDR_W'(1);
        wa[2] = i_wr_1_addr;
        wa[3] = i_wr_1_addr + ADDR_W'(1);
        wd[0] = i_wr_0_data;
        wd[1] = i_wr_0_data_x2;
        wd[2] = i_wr_1_data;
        wd[3] = i_wr_1_data_x2;
        wv    = {i_wr_1_en & i_wr_1_x2_en, i_wr_1_en, i_wr_0_en & i_wr_0_x2_en, i_wr_0_en};
        ra[0] = i_rd_0_addr;
        ra[1] = i_rd_0_addr + ADDR_W'(1);
        ra[2] = i_rd_1_addr;
        ra[3] = i_rd_1_addr + ADDR_W'(1);
        rv    = {i_rd_1_en & i_rd_1_x2_en, i_rd_1_en, i_rd_0_en & i_rd_0_x2_en, i_rd_0_en};
        oor_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            we[i] = wv[i] && in_range(wa[i]) && !busy;
            if ((wv[i] && !in_range(wa[i])) || (rv[i] && !in_range(ra[i])))
                oor_hit = 1'b1;
        end
    end

    // Read lookup with write-first forwarding; busy or out-of-range reads give 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdv[i] = '0;
            if (rv[i] && in_range(ra[i]) && !busy) begin
                rdv[i] = mem_q[ra[i][MEM_AW-1:0]];
                for (int j = 0; j < 4; j++)
                    if (we[j] && wa[j] == ra[i])
                        rdv[i] = wd[j];
            end
        end
    end

    // Array update: clear engine owns the array while busy; lanes commit in priority order.
    always_ff @(posedge i_clk) begin
        if (busy && !i_rst) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int j = 0; j < 4; j++)
                if (we[j])
                    mem_q[wa[j][MEM_AW-1:0]] <= wd[j];
        end
    end

    // Control FSM, sticky error flag and registered read outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            clr_cnt_q     <= '0;
            rst_seen_q    <= 1'b1;
            oor_q         <= 1'b0;
            rd0_data_q    <= '0;
            rd0_data_x2_q <= '0;
            rd0_valid_q   <= 1'b0;
            rd1_data_q    <= '0;
            rd1_data_x2_q <= '0;
            rd1_valid_q   <= 1'b0;
        end else begin
            rst_seen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_clr || (rst_seen_q && CLEAR_ON_RESET)) begin
                        state_q   <= S_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + MEM_AW'(1);
                    if (clr_cnt_q == MEM_AW'(DEPTH - 1))
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (oor_hit)
                oor_q <= 1'b1;
            rd0_valid_q <= i_rd_0_en;
            if (i_rd_0_en) begin
                rd0_data_q    <= rdv[0];
                rd0_data_x2_q <= i_rd_0_x2_en ? rdv[1] : '0;
            end
            rd1_valid_q <= i_rd_1_en;
            if (i_rd_1_en) begin
                rd1_data_q    <= rdv[2];
                rd1_data_x2_q <= i_rd_1_x2_en ? rdv[3] : '0;
            end
        end
    end

    assign o_busy         = busy;
    assign o_oor_err      = oor_q;
    assign o_rd_0_data    = rd0_data_q;
    assign o_rd_0_data_x2 = rd0_data_x2_q;
    assign o_rd_0_valid   = rd0_valid_q;
    assign o_rd_1_data    = rd1_data_q;
    assign o_rd_1_data_x2 = rd1_data_x2_q;
    assign o_rd_1_valid   = rd1_valid_q;

endmodule
